// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment scanner: hex/BCD decode, dp, zero suppression, blink, PWM, double-buffered load.
// Latency: segment/enable registered one cycle after the div_cnt/scan_idx state they show.
// No backpressure: load is accepted every cycle; the newest staged data wins at the next frame wrap.
module seg_scan_display #(
  parameter int NUM_DIGITS = 8,
  parameter int DIV_W      = 16,
  parameter int BLINK_W    = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    load,
  input  logic                    hex_mode,
  input  logic                    lzs,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [3:0]              brightness,
  output logic [7:0]              segment,
  output logic [NUM_DIGITS-1:0]   enable,
  output logic                    pending,
  output logic                    frame_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0]        div_cnt;
  logic [IDX_W-1:0]        scan_idx;
  logic [BLINK_W-1:0]      frame_cnt;
  logic [4*NUM_DIGITS-1:0] stage_dig, act_dig;
  logic [NUM_DIGITS-1:0]   stage_dp, act_dp;

  logic slot_end, frame_wrap;
  assign slot_end   = &div_cnt;
  assign frame_wrap = slot_end && (scan_idx == LAST_IDX);

  // Slot timer, digit pointer and frame counter; frame_tick marks the first cycle of a new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      scan_idx   <= '0;
      frame_cnt  <= '0;
      frame_tick <= 1'b0;
    end else begin
      div_cnt    <= div_cnt + DIV_W'(1);
      frame_tick <= frame_wrap;
      if (slot_end)
        scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + IDX_W'(1);
      if (frame_wrap)
        frame_cnt <= frame_cnt + BLINK_W'(1);
    end
  end

  // Staging/active buffers: the active copy only changes at a frame wrap, so a frame never tears.
  // A load on the wrap cycle lands in staging after the old staging has moved to active.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_dig <= '0;
      stage_dp  <= '0;
      act_dig   <= '0;
      act_dp    <= '0;
      pending   <= 1'b0;
    end else begin
      if (frame_wrap && pending) begin
        act_dig <= stage_dig;
        act_dp  <= stage_dp;
        pending <= 1'b0;
      end
      if (load) begin
        stage_dig <= digits;
        stage_dp  <= dp;
        pending   <= 1'b1;
      end
    end
  end

  logic [3:0]            sel_val;
  logic                  sel_dp;
  logic [6:0]            seg7;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  zero_run;
  logic                  blank;
  logic                  pwm_on;
  logic [7:0]            seg_nxt;
  logic [NUM_DIGITS-1:0] en_nxt;

  // Decode the selected active digit and work out blanking and the PWM-gated digit select.
  always_comb begin
    sel_val  = act_dig[{scan_idx, 2'b00} +: 4];
    sel_dp   = act_dp[scan_idx];
    lz_blank = '0;
    zero_run = lzs;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run    = zero_run && (act_dig[4*i +: 4] == 4'd0);
      lz_blank[i] = zero_run;
    end
    case (sel_val)
      4'h0: seg7 = 7'b0000001;
      4'h1: seg7 = 7'b1001111;
      4'h2: seg7 = 7'b0010010;
      4'h3: seg7 = 7'b0000110;
      4'h4: seg7 = 7'b1001100;
      4'h5: seg7 = 7'b0100100;
      4'h6: seg7 = 7'b0100000;
      4'h7: seg7 = 7'b0001111;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0000100;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b1100000;
      4'hC: seg7 = 7'b0110001;
      4'hD: seg7 = 7'b1000010;
      4'hE: seg7 = 7'b0110000;
      default: seg7 = 7'b0111000;
    endcase
    if (!hex_mode && (sel_val > 4'd9))
      seg7 = 7'b1111111;
    blank   = lz_blank[scan_idx] || (blink_mask[scan_idx] && frame_cnt[BLINK_W-1]);
    seg_nxt = blank ? 8'hFF : {seg7, ~sel_dp};
    pwm_on  = div_cnt[DIV_W-1 -: 4] < brightness;
    en_nxt  = '1;
    for (int i = 0; i < NUM_DIGITS; i++)
      en_nxt[i] = !(pwm_on && (scan_idx == IDX_W'(i)));
  end

  // Register segment and enable together so the pins change on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      segment <= 8'hFF;
      enable  <= '1;
    end else begin
      segment <= seg_nxt;
      enable  <= en_nxt;
    end
  end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Parametrised multiplexed 7-segment driver; successor to the fixed 8-digit BCD scanner.
- Adds:
  - configurable digit count and scan rate
  - hex/BCD decode
  - per-digit decimal points
  - leading-zero suppression
  - per-digit blink
  - 4-bit PWM brightness
  - tear-free double-buffered digit load
- Sits between game/score logic and the board's common-anode display pins.

Parameters:
- NUM_DIGITS, 8, number of digits scanned (1..16)
- DIV_W, 16, width of slot counter; each digit is lit for 2^DIV_W clk cycles (DIV_W >= 4)
- BLINK_W, 6, width of frame counter; blink phase is its MSB

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- digits  in  4*NUM_DIGITS  digit values, digit i at [4i+3:4i]; digit 0 is rightmost
- dp  in  NUM_DIGITS  decimal point per digit, 1 = lit
- load  in  1  strobe: capture digits/dp into staging buffer
- hex_mode  in  1  1 = decode 0-F, 0 = BCD (10-15 blank)
- lzs  in  1  leading-zero suppression enable
- blink_mask  in  NUM_DIGITS  1 = digit blinks
- brightness  in  4  PWM duty, 0 = off, 15 = 15/16
- segment  out  8  bit7..bit1 = a..g, bit0 = dp, active low
- enable  out  NUM_DIGITS  digit select, active low, enable[i] drives digit i
- pending  out  1  staging buffer holds data not yet displayed
- frame_tick  out  1  one-cycle pulse at each frame wrap

Behaviour:
- **Reset** (rst high at posedge clk):
  - slot counter, scan_idx and frame counter cleared to 0
  - staging and active buffers cleared to 0
  - pending = 0, frame_tick = 0
  - segment = 8'hFF, enable = all ones
- **Slot counter:**
  - div_cnt (DIV_W bits) increments every cycle and wraps.
  - When div_cnt = all ones, scan_idx advances next cycle: 0..NUM_DIGITS-1, then wraps to 0.
- **Frame wrap:** scan_idx moves NUM_DIGITS-1 -> 0. On that cycle:
  - frame counter increments (wraps)
  - frame_tick pulses high for exactly one cycle
  - if pending = 1, staging is copied to the active buffer and pending clears
- **Load:**
  - load = 1 copies digits/dp into staging and sets pending = 1.
  - A load while pending overwrites staging; only one transfer occurs.
  - If load coincides with the frame wrap, the new data goes to staging and pending stays 1. The old staging contents transfer this wrap; the new data transfers at the next wrap.
- The display reads only the active buffer, so a frame never mixes old and new data.
- **Decode** (active-low abcdefg):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
  - When hex_mode = 0, values 10-15 decode to 1111111.
  - segment[0] = ~dp of the selected digit.
- **Leading-zero suppression** (lzs = 1):
  - Active digits from NUM_DIGITS-1 downward whose value is 0 are blanked, up to the first nonzero digit.
  - Digit 0 is never suppressed.
  - A suppressed digit's dp is also blanked.
  - Evaluated on the active buffer.
- **Blink:** digit i is blank when blink_mask[i] = 1 and the frame counter MSB = 1.
- **PWM:**
  - The selected digit's enable is asserted only while div_cnt[DIV_W-1:DIV_W-4] < brightness.
  - brightness = 0 keeps enable all ones.
  - brightness is sampled live.
- **Blank digit:** enable is still asserted per PWM; segment = 8'hFF.
- **Output timing:**
  - segment and enable are registered together, one cycle after the div_cnt/scan_idx state they reflect.
  - At most one enable bit is low at any time.
- hex_mode, lzs and blink_mask are sampled live; they are not double-buffered.

Test Plan (NUM_DIGITS=4, DIV_W=4, BLINK_W=2):
1. **Reset:** assert rst mid-scan with enable = 4'b1011 -> next cycle segment = 8'hFF, enable = 4'hF, pending = 0; after release, digit 0 is scanned first.
2. **Load and frame boundary:**
   - Stimulus: brightness = 15, load digits = 16'h1234, dp = 4'b0010.
   - pending = 1 until the next frame_tick; nothing changes mid-frame.
   - Next frame: digit 0 shows 4 = 10011001, digit 1 shows 3 with dp = 00001100, digit 3 shows 1.
   - Each digit is lit 15 of 16 cycles.
3. **Decode modes:**
   - digits = 16'h00AF, hex_mode = 1 -> digit 1 shows A = 00010001, digit 0 shows F = 01110001.
   - hex_mode = 0 -> both show 8'hFF.
4. **Leading-zero suppression:**
   - lzs = 1, digits = 16'h0050 -> digits 3 and 2 blank, digit 1 shows 5, digit 0 shows 0.
   - digits = 16'h0000 -> only digit 0 shows 0.
5. **Blink and PWM:**
   - blink_mask = 4'b0001 -> digit 0 blank for frames 2-3 of every 4, lit for frames 0-1.
   - brightness = 4 -> each slot's enable is low for exactly 4 of 16 cycles.
   - brightness = 0 -> enable stays 4'hF.
6. **Load collisions:**
   - Load 16'h1111 then 16'h2222 in the same frame -> only 2222 is displayed.
   - Load coinciding with a frame_tick -> that data is displayed one frame later; pending stays 1 across the wrap.
